// File: rtl/charmatrix_pkg.sv
// Shared constants, FSM state type and position helper for the 5x7
// character-matrix LED frame sequencer.
package charmatrix_pkg;

   localparam int GLYPH_ROWS    = 7;
   localparam int GLYPH_COLS    = 5;
   localparam int LEDS_PER_CHAR = GLYPH_ROWS * GLYPH_COLS;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_LATCH  = 2'd3
   } seq_state_e;

   // True when a 3-bit wrap counter sits on its final value for a span of 'count'.
   function automatic logic is_last_pos(input logic [2:0] pos, input int count);
      return (pos == 3'(count - 1));
   endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Pixel-address handshake between the frame sequencer (master) and the
// LED serializer (slave).
interface led_frame_sequencer_if;

   logic       pix_valid;
   logic       pix_ready;
   logic [8:0] led_idx;
   logic [2:0] char_idx;
   logic [2:0] col;
   logic [2:0] row;
   logic       last_char;

   modport master (
      output pix_valid,
      output led_idx,
      output char_idx,
      output col,
      output row,
      output last_char,
      input  pix_ready
   );

   modport slave (
      input  pix_valid,
      input  led_idx,
      input  char_idx,
      input  col,
      input  row,
      input  last_char,
      output pix_ready
   );

endinterface

// File: rtl/glyph_pos_counter.sv
// Cascaded row -> column -> character wrap counters plus the linear LED index;
// replaces any divide/modulo of the LED index by the glyph geometry.
module glyph_pos_counter
   import charmatrix_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       adv,
   input  logic [2:0] chars_m1_next,
   output logic [8:0] led_idx,
   output logic [2:0] char_idx,
   output logic [2:0] col,
   output logic [2:0] row,
   output logic       last_char
);

   logic [8:0] led_idx_r,  led_idx_next_s;
   logic [2:0] char_idx_r, char_idx_next_s;
   logic [2:0] col_r,      col_next_s;
   logic [2:0] row_r,      row_next_s;
   logic       last_char_r, last_char_next_s;

   // Next position: clear wins over advance; rows wrap into columns, columns into characters.
   always_comb begin
      led_idx_next_s  = led_idx_r;
      char_idx_next_s = char_idx_r;
      col_next_s      = col_r;
      row_next_s      = row_r;
      if (clr) begin
         led_idx_next_s  = 9'd0;
         char_idx_next_s = 3'd0;
         col_next_s      = 3'd0;
         row_next_s      = 3'd0;
      end else if (adv) begin
         led_idx_next_s = led_idx_r + 9'd1;
         if (is_last_pos(row_r, GLYPH_ROWS)) begin
            row_next_s = 3'd0;
            if (is_last_pos(col_r, GLYPH_COLS)) begin
               col_next_s      = 3'd0;
               char_idx_next_s = char_idx_r + 3'd1;
            end else begin
               col_next_s = col_r + 3'd1;
            end
         end else begin
            row_next_s = row_r + 3'd1;
         end
      end else begin
         led_idx_next_s = led_idx_r;
      end
      // Registered against the config value that will be latched on the same edge.
      last_char_next_s = (char_idx_next_s == chars_m1_next);
   end

   // Position registers; last_char resets high because char 0 matches a cleared config.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_idx_r   <= 9'd0;
         char_idx_r  <= 3'd0;
         col_r       <= 3'd0;
         row_r       <= 3'd0;
         last_char_r <= 1'b1;
      end else begin
         led_idx_r   <= led_idx_next_s;
         char_idx_r  <= char_idx_next_s;
         col_r       <= col_next_s;
         row_r       <= row_next_s;
         last_char_r <= last_char_next_s;
      end
   end

   assign led_idx   = led_idx_r;
   assign char_idx  = char_idx_r;
   assign col       = col_r;
   assign row       = row_r;
   assign last_char = last_char_r;

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame sequencer for a character-matrix LED string: walks pixel addresses
// through the serializer handshake, then holds the latch gap before repeating.
module led_frame_sequencer
   import charmatrix_pkg::*;
#(
   parameter int LATCH_CYCLES = 4000
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  auto_repeat,
   input  logic [2:0]            num_chars_m1,
   input  logic [8:0]            num_leds_m1,
   led_frame_sequencer_if.master pix,
   output logic                  latch_active,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int LATCH_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);

   seq_state_e         state_r, state_next_s;
   logic [LATCH_W-1:0] latch_cnt_r, latch_cnt_next_s;
   logic [2:0]         num_chars_r, num_chars_next_s;
   logic [8:0]         num_leds_r, num_leds_next_s;
   logic               clr_s;
   logic               adv_s;
   logic               pix_valid_r;
   logic               busy_r;
   logic               latch_active_r;
   logic               frame_done_r;

   // Next-state, config capture and counter control.
   always_comb begin
      state_next_s     = state_r;
      latch_cnt_next_s = latch_cnt_r;
      num_chars_next_s = num_chars_r;
      num_leds_next_s  = num_leds_r;
      clr_s            = 1'b0;
      adv_s            = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_LOAD;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            num_chars_next_s = num_chars_m1;
            num_leds_next_s  = num_leds_m1;
            latch_cnt_next_s = {LATCH_W{1'b0}};
            clr_s            = 1'b1;
            state_next_s     = ST_STREAM;
         end
         ST_STREAM: begin
            if (pix.pix_ready) begin
               adv_s = 1'b1;
               if (pix.led_idx == num_leds_r) begin
                  state_next_s     = ST_LATCH;
                  latch_cnt_next_s = {LATCH_W{1'b0}};
               end else begin
                  state_next_s = ST_STREAM;
               end
            end else begin
               state_next_s = ST_STREAM;
            end
         end
         ST_LATCH: begin
            if (latch_cnt_r == LATCH_LAST) begin
               if (auto_repeat) begin
                  state_next_s = ST_LOAD;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               latch_cnt_next_s = latch_cnt_r + {{(LATCH_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, config and status registers; status flags are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         latch_cnt_r    <= {LATCH_W{1'b0}};
         num_chars_r    <= 3'd0;
         num_leds_r     <= 9'd0;
         pix_valid_r    <= 1'b0;
         busy_r         <= 1'b0;
         latch_active_r <= 1'b0;
         frame_done_r   <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         latch_cnt_r    <= latch_cnt_next_s;
         num_chars_r    <= num_chars_next_s;
         num_leds_r     <= num_leds_next_s;
         pix_valid_r    <= (state_next_s == ST_STREAM);
         busy_r         <= (state_next_s != ST_IDLE);
         latch_active_r <= (state_next_s == ST_LATCH);
         frame_done_r   <= (state_next_s == ST_LATCH) && (latch_cnt_next_s == LATCH_LAST);
      end
   end

   glyph_pos_counter u_pos (
      .clk           (clk),
      .rst           (rst),
      .clr           (clr_s),
      .adv           (adv_s),
      .chars_m1_next (num_chars_next_s),
      .led_idx       (pix.led_idx),
      .char_idx      (pix.char_idx),
      .col           (pix.col),
      .row           (pix.row),
      .last_char     (pix.last_char)
   );

   assign pix.pix_valid = pix_valid_r;
   assign latch_active  = latch_active_r;
   assign busy          = busy_r;
   assign frame_done    = frame_done_r;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomized self-checking bench for led_frame_sequencer; expected addresses
// come from the index arithmetic of the glyph layout (k mod 35, /7, mod 7).
module tb_led_frame_sequencer;

   localparam int LATCH_N = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       auto_repeat;
   logic [2:0] num_chars_m1;
   logic [8:0] num_leds_m1;
   logic       latch_active;
   logic       busy;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   led_frame_sequencer_if pix_bus ();

   led_frame_sequencer #(.LATCH_CYCLES(LATCH_N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .auto_repeat  (auto_repeat),
      .num_chars_m1 (num_chars_m1),
      .num_leds_m1  (num_leds_m1),
      .pix          (pix_bus.master),
      .latch_active (latch_active),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: transfer k of a frame addresses LED k of a 5x7 column-major glyph chain.
   task automatic expect_pixel(input int k, input int chars_m1);
      int ch;
      ch = (k / 35) % 8;
      check("pix_valid", pix_bus.pix_valid, 1);
      check("led_idx", pix_bus.led_idx, k % 512);
      check("char_idx", pix_bus.char_idx, ch);
      check("col", pix_bus.col, (k % 35) / 7);
      check("row", pix_bus.row, k % 7);
      check("last_char", pix_bus.last_char, (ch == chars_m1) ? 1 : 0);
   endtask

   task automatic start_frame(input int leds_m1, input int chars_m1);
      num_leds_m1  = 9'(leds_m1);
      num_chars_m1 = 3'(chars_m1);
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("load_busy", busy, 1);
      check("load_valid", pix_bus.pix_valid, 0);
      @(negedge clk);
   endtask

   task automatic stream_and_latch(input int leds_m1, input int chars_m1, input int rdy_pct,
                                   input bit disturb, input bit auto_on);
      int k;
      int cyc;
      bit rdy;
      k   = 0;
      cyc = 0;
      while (k <= leds_m1 && cyc < 4000) begin
         expect_pixel(k, chars_m1);
         check("done_in_stream", frame_done, 0);
         if (leds_m1 == 69 && k == 34) begin
            check("t34_char", pix_bus.char_idx, 0);
            check("t34_col", pix_bus.col, 4);
            check("t34_row", pix_bus.row, 6);
         end
         if (leds_m1 == 69 && k == 35) begin
            check("t35_char", pix_bus.char_idx, 1);
            check("t35_col", pix_bus.col, 0);
            check("t35_row", pix_bus.row, 0);
            check("t35_last", pix_bus.last_char, 1);
         end
         rdy = ($urandom_range(0, 99) < rdy_pct);
         pix_bus.pix_ready = rdy;
         if (disturb) begin
            start        = 1'($urandom_range(0, 1));
            num_leds_m1  = 9'($urandom);
            num_chars_m1 = 3'($urandom);
         end
         @(negedge clk);
         cyc++;
         if (rdy) k++;
      end
      if (cyc >= 4000) check("stream_timeout", k, leds_m1 + 1);
      for (int i = 0; i < LATCH_N; i++) begin
         check("latch_active", latch_active, 1);
         check("latch_valid", pix_bus.pix_valid, 0);
         check("frame_done", frame_done, (i == LATCH_N - 1) ? 1 : 0);
         pix_bus.pix_ready = 1'($urandom_range(0, 1));
         if (disturb) begin
            start        = 1'($urandom_range(0, 1));
            num_leds_m1  = 9'($urandom);
            num_chars_m1 = 3'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("post_latch_active", latch_active, 0);
      check("post_done", frame_done, 0);
      check("post_valid", pix_bus.pix_valid, 0);
      if (auto_on) begin
         check("auto_load_busy", busy, 1);
         auto_repeat = 1'b0;
         @(negedge clk);
      end else begin
         for (int i = 0; i < 3; i++) begin
            check("idle_busy", busy, 0);
            check("idle_valid", pix_bus.pix_valid, 0);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      int l;
      int c;
      int fd;
      rst               = 1'b1;
      start             = 1'b0;
      auto_repeat       = 1'b0;
      num_chars_m1      = 3'd0;
      num_leds_m1       = 9'd0;
      pix_bus.pix_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", pix_bus.pix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_latch", latch_active, 0);
      check("rst_done", frame_done, 0);
      check("rst_led", pix_bus.led_idx, 0);
      check("rst_char", pix_bus.char_idx, 0);
      check("rst_col", pix_bus.col, 0);
      check("rst_row", pix_bus.row, 0);
      check("rst_last", pix_bus.last_char, 1);
      rst = 1'b0;
      @(negedge clk);
      check("idle_hold", busy, 0);

      start_frame(69, 1);
      stream_and_latch(69, 1, 100, 1'b0, 1'b0);
      start_frame(104, 4);
      stream_and_latch(104, 4, 50, 1'b0, 1'b0);
      start_frame(279, 7);
      stream_and_latch(279, 7, 70, 1'b0, 1'b0);
      start_frame(0, 0);
      stream_and_latch(0, 0, 60, 1'b0, 1'b0);

      // Reset mid-stream at led_idx 40.
      start_frame(100, 2);
      pix_bus.pix_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         expect_pixel(k, 2);
         @(negedge clk);
      end
      check("pre_rst_led", pix_bus.led_idx, 40);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", pix_bus.pix_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_led", pix_bus.led_idx, 0);
      check("mid_rst_done", frame_done, 0);
      check("mid_rst_last", pix_bus.last_char, 1);
      fd = 0;
      for (int i = 0; i < 30; i++) begin
         fd += int'(frame_done);
         @(negedge clk);
      end
      check("rst_no_done", fd, 0);
      check("rst_stays_idle", busy, 0);

      start_frame(50, 3);
      stream_and_latch(50, 3, 60, 1'b1, 1'b0);

      auto_repeat = 1'b1;
      start_frame(9, 0);
      stream_and_latch(9, 0, 80, 1'b0, 1'b1);
      stream_and_latch(9, 0, 80, 1'b0, 1'b0);

      repeat (3) begin
         l = $urandom_range(0, 200);
         c = $urandom_range(0, 7);
         start_frame(l, c);
         stream_and_latch(l, c, $urandom_range(20, 100), 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_frame_sequencer.md
LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 SHALL have parameter LATCH_CYCLES, default 4000, giving the latch/reset gap length in clk cycles (80 us at 50 MHz).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one frame.
REQ-005 SHALL have port auto_repeat  input  1  when high, start the next frame immediately after a frame ends.
REQ-006 SHALL have port num_chars_m1  input  3  character count minus 1.
REQ-007 SHALL have port num_leds_m1  input  9  LED count minus 1.
REQ-008 SHALL have port pix_valid  output  1  pixel address offered to the serializer.
REQ-009 SHALL have port pix_ready  input  1  serializer accepts the offered pixel.
REQ-010 SHALL have port led_idx  output  9  linear LED index.
REQ-011 SHALL have port char_idx  output  3  character index.
REQ-012 SHALL have port col  output  3  glyph column, 0..4.
REQ-013 SHALL have port row  output  3  glyph row, 0..6.
REQ-014 SHALL have port last_char  output  1  high when char_idx == latched num_chars_m1.
REQ-015 SHALL have port latch_active  output  1  high during the latch gap.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, LOAD, STREAM, LATCH.
REQ-019 In IDLE, start=1 SHALL move the FSM to LOAD on the next edge.
REQ-020 In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-021 LOAD SHALL register num_chars_m1 and num_leds_m1, clear all counters, and go to STREAM after one cycle.
REQ-022 Config input changes during STREAM or LATCH SHALL be ignored.
REQ-023 pix_valid SHALL be 1 exactly while the FSM is in STREAM, so pix_valid with led_idx=0 appears 2 cycles after start is sampled.
REQ-024 A transfer SHALL occur on a cycle where pix_valid and pix_ready are both 1.
REQ-025 The address outputs SHALL stay stable until a transfer occurs.
REQ-026 A transfer SHALL update the address outputs on the next edge.
REQ-027 Scan order SHALL be: led_idx increments by 1.
REQ-028 Within a character, row SHALL increment 0..6, then wrap to 0 while col increments.
REQ-029 After col=4,row=6, col SHALL return to 0 and char_idx SHALL increment.
REQ-030 The equivalent mapping SHALL be: pixel index = led_idx mod 35; col = pixel index / 7; row = pixel index mod 7.
REQ-031 All address arithmetic SHALL use wrap counters; no dividers.
REQ-032 A transfer at led_idx == latched num_leds_m1 SHALL be the final transfer of the frame.
REQ-033 After the final transfer, the FSM SHALL go to LATCH and pix_valid SHALL drop on the next edge.
REQ-034 If num_leds_m1 is not a multiple of 35 minus 1, the frame SHALL still end at num_leds_m1, even mid-glyph.
REQ-035 LATCH SHALL hold latch_active=1 for exactly LATCH_CYCLES cycles.
REQ-036 On the last LATCH cycle, frame_done SHALL pulse for 1 cycle.
REQ-037 After LATCH, the FSM SHALL go to LOAD if auto_repeat=1, otherwise to IDLE.
REQ-038 start SHALL be ignored while busy=1.
REQ-039 pix_ready SHALL be ignored outside STREAM.

Reset
REQ-040 On a cycle with rst=1, the FSM SHALL enter IDLE.
REQ-041 rst=1 SHALL clear all counters and latched config.
REQ-042 rst=1 SHALL drive pix_valid, latch_active, busy and frame_done to 0.
REQ-043 rst=1 SHALL drive led_idx, char_idx, col and row to 0.
REQ-044 last_char SHALL reset to 1, since char_idx=0 equals the cleared config value 0.
REQ-045 rst SHALL take priority over every other input, including mid-STREAM and mid-LATCH.
REQ-046 No frame_done pulse SHALL be emitted because of reset.

Structure
REQ-047 Shared package charmatrix_pkg SHALL hold GLYPH_ROWS=7, GLYPH_COLS=5, LEDS_PER_CHAR=35, and the FSM state typedef.
REQ-048 Sub-module glyph_pos_counter SHALL hold the row/col/char_idx wrap counters and have inputs clr and adv.
REQ-049 The latch-gap counter and the FSM SHALL stay in the top module.

Verification
REQ-050 Scenario 1: num_leds_m1=69, num_chars_m1=1, pix_ready=1, start pulse -> 70 transfers; transfer 34 has char 0/col 4/row 6; transfer 35 has char 1/col 0/row 0 with last_char=1; then latch_active for LATCH_CYCLES (bench uses 16); then frame_done.
REQ-051 Scenario 2: pix_ready toggles randomly -> address outputs never change without a transfer; led_idx sequence is gap-free.
REQ-052 Scenario 3: num_leds_m1=279, num_chars_m1=7 -> 280 transfers; final transfer has char_idx=7, col=4, row=6.
REQ-053 Scenario 4: rst asserted at led_idx=40 -> next cycle shows IDLE, pix_valid=0, led_idx=0, and no frame_done.
REQ-054 Scenario 5: start pulses and config changes during STREAM -> frame length unchanged and no second frame.
REQ-055 Scenario 6: auto_repeat=1 -> LOAD follows LATCH directly; the second frame begins with led_idx=0, 2 cycles after frame_done.
